pid_tx_encoder: RTL and testbench

//  Transmit-side counterpart of the receiver PID FIFO. Pops one PID byte at a time from an upstream
//  8-bit first-word-fall-through FIFO, validates the check nibble, and drives a full-speed USB

---
 rtl/pid_tx_encoder.sv | 137 +++++++++++++
 tb/tb_pid_tx_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_tx_encoder.sv
// rtl/pid_tx_encoder.sv - pops a PID byte, checks it, sends SYNC+PID+EOP as NRZI with bit stuffing
module pid_tx_encoder #(
    parameter logic [7:0] SYNC_BYTE    = 8'h80,
    parameter int         EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       shift_strobe,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_r_data,
    output logic       fifo_r_enable,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_active,
    output logic       pid_error
);

    typedef enum logic [2:0] {IDLE, FETCH, CHECK, SEND, EOP, EOP_J} state_t;

    localparam logic [1:0] SE0_LAST = 2'(EOP_SE0_BITS - 1);

    state_t      state_q, state_d;
    logic [7:0]  pid_q, pid_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  ones_cnt_q, ones_cnt_d;
    logic [1:0]  se0_cnt_q, se0_cnt_d;
    logic        dplus_q, dplus_d;
    logic        dminus_q, dminus_d;
    logic        tx_active_q, tx_active_d;
    logic        pid_ok;

    assign pid_ok        = (pid_q[7:4] == ~pid_q[3:0]);
    assign fifo_r_enable = (state_q == FETCH);
    assign pid_error     = (state_q == CHECK) && !pid_ok;
    assign dplus_out     = dplus_q;
    assign dminus_out    = dminus_q;
    assign tx_active     = tx_active_q;

    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        se0_cnt_d   = se0_cnt_q;
        dplus_d     = dplus_q;
        dminus_d    = dminus_q;
        tx_active_d = tx_active_q;
        case (state_q)
            IDLE: begin
                tx_active_d = 1'b0;
                if (!fifo_empty) state_d = FETCH;
            end
            FETCH: begin
                pid_d   = fifo_r_data;
                state_d = CHECK;
            end
            CHECK: begin
                if (pid_ok) begin
                    shift_d    = {pid_q, SYNC_BYTE};
                    bit_cnt_d  = 5'd0;
                    ones_cnt_d = 3'd0;
                    se0_cnt_d  = 2'd0;
                    state_d    = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (shift_strobe) begin
                    tx_active_d = 1'b1;
                    if (ones_cnt_q == 3'd6) begin
                        dplus_d    = ~dplus_q;
                        dminus_d   = dplus_q;
                        ones_cnt_d = 3'd0;
                        if (bit_cnt_q == 5'd16) state_d = EOP;
                    end else begin
                        if (shift_q[0]) begin
                            ones_cnt_d = ones_cnt_q + 3'd1;
                        end else begin
                            dplus_d    = ~dplus_q;
                            dminus_d   = dplus_q;
                            ones_cnt_d = 3'd0;
                        end
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        // last data bit: leave SEND unless a trailing stuff bit is owed
                        if (bit_cnt_q == 5'd15 && !(shift_q[0] && ones_cnt_q == 3'd5))
                            state_d = EOP;
                    end
                end
            end
            EOP: begin
                if (shift_strobe) begin
                    dplus_d   = 1'b0;
                    dminus_d  = 1'b0;
                    se0_cnt_d = se0_cnt_q + 2'd1;
                    if (se0_cnt_q == SE0_LAST) state_d = EOP_J;
                end
            end
            EOP_J: begin
                if (shift_strobe) begin
                    dplus_d  = 1'b1;
                    dminus_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            pid_q       <= 8'd0;
            shift_q     <= 16'd0;
            bit_cnt_q   <= 5'd0;
            ones_cnt_q  <= 3'd0;
            se0_cnt_q   <= 2'd0;
            dplus_q     <= 1'b1;
            dminus_q    <= 1'b0;
            tx_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            se0_cnt_q   <= se0_cnt_d;
            dplus_q     <= dplus_d;
            dminus_q    <= dminus_d;
            tx_active_q <= tx_active_d;
        end
    end

endmodule

// File: tb/tb_pid_tx_encoder.sv
// tb/tb_pid_tx_encoder.sv - randomized self-checking bench for pid_tx_encoder (two parameter sets)
module tb_pid_tx_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic shift_strobe = 1'b0;
    int   strobe_div = 3;
    int   div_cnt = 0;

    logic [1:0]      fifo_empty;
    logic [1:0][7:0] fifo_r_data;
    logic [1:0]      fifo_r_enable, dplus, dminus, tx_active, pid_error;

    logic [7:0] fmem [2][64];
    int         fwr[2], frd[2];
    logic [1:0] exp_mem [2][1024];
    int         ewr[2], erd[2];
    int         pops[2], exp_pops[2], perr[2], exp_perr[2], txs[2], idle_st[2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_cnt >= strobe_div) begin
            shift_strobe = 1'b1;
            div_cnt = 0;
        end else begin
            shift_strobe = 1'b0;
            div_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put_sym(input int g, input logic [1:0] s);
        exp_mem[g][ewr[g] % 1024] = s;
        ewr[g]++;
    endtask

    // Reference: bit stream LSB first, stuff a 0 after six 1s, NRZI (0 = transition), then EOP.
    task automatic push_pid(input int g, input logic [7:0] pid);
        logic [15:0] bits;
        logic [1:0]  line;
        int          ones;
        bits = {pid, (g == 0) ? 8'h80 : 8'hC0};
        line = 2'b10;
        ones = 0;
        exp_pops[g]++;
        if (pid[7:4] != ~pid[3:0]) begin
            exp_perr[g]++;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (bits[i]) ones++;
                else begin
                    line = ~line;
                    ones = 0;
                end
                put_sym(g, line);
                if (ones == 6) begin
                    line = ~line;
                    put_sym(g, line);
                    ones = 0;
                end
            end
            for (int i = 0; i < ((g == 0) ? 2 : 3); i++) put_sym(g, 2'b00);
            put_sym(g, 2'b10);
        end
        fmem[g][fwr[g] % 64] = pid;
        fwr[g]++;
    endtask

    for (genvar g = 0; g < 2; g++) begin : ch
        logic       st, e0, en, prev_en;
        logic [1:0] prev_line, line;

        assign fifo_empty[g]  = (frd[g] == fwr[g]);
        assign fifo_r_data[g] = fmem[g][frd[g] % 64];
        assign line           = {dplus[g], dminus[g]};

        pid_tx_encoder #(
            .SYNC_BYTE   ((g == 0) ? 8'h80 : 8'hC0),
            .EOP_SE0_BITS((g == 0) ? 2 : 3)
        ) u_dut (
            .clk          (clk),
            .n_rst        (rst_n),
            .shift_strobe (shift_strobe),
            .fifo_empty   (fifo_empty[g]),
            .fifo_r_data  (fifo_r_data[g]),
            .fifo_r_enable(fifo_r_enable[g]),
            .dplus_out    (dplus[g]),
            .dminus_out   (dminus[g]),
            .tx_active    (tx_active[g]),
            .pid_error    (pid_error[g])
        );

        initial begin
            prev_en = 1'b0;
            prev_line = 2'b10;
        end

        always @(posedge clk) begin
            st = shift_strobe;
            e0 = fifo_empty[g];
            en = fifo_r_enable[g];
            #1;
            if (!rst_n) begin
                erd[g] = ewr[g];
            end else begin
                if (en) begin
                    chk($sformatf("pop_nonempty%0d", g), {31'd0, e0}, 0);
                    frd[g]++;
                    pops[g]++;
                end
                if (pid_error[g]) begin
                    perr[g]++;
                    chk($sformatf("err_after_pop%0d", g), {31'd0, prev_en}, 1);
                end
                if (!st) chk($sformatf("hold%0d", g), {30'd0, line}, {30'd0, prev_line});
                if (!tx_active[g]) begin
                    chk($sformatf("idle_j%0d", g), {30'd0, line}, 2);
                    if (st && !fifo_empty[g]) idle_st[g]++;
                end else if (st) begin
                    txs[g]++;
                    if (erd[g] == ewr[g]) chk($sformatf("extra_sym%0d", g), 1, 0);
                    else begin
                        chk($sformatf("sym%0d_%0d", g, erd[g]), {30'd0, line},
                            {30'd0, exp_mem[g][erd[g] % 1024]});
                        erd[g]++;
                    end
                end
            end
            prev_en = fifo_r_enable[g];
            prev_line = line;
        end
    end

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (fifo_empty == 2'b11 && erd[0] == ewr[0] && erd[1] == ewr[1] && tx_active == 2'b00)
                done = 1'b1;
        end
        if (!done) chk("timeout", 0, 1);
        repeat (8) @(negedge clk);
    endtask

    task automatic align_strobe();
        do @(posedge clk); while (!shift_strobe);
        @(negedge clk);
    endtask

    initial begin
        int t0, n, s0;
        logic [7:0] pid;
        bit hit;
        for (int g = 0; g < 2; g++) begin
            fwr[g] = 0; frd[g] = 0; ewr[g] = 0; erd[g] = 0; pops[g] = 0; exp_pops[g] = 0;
            perr[g] = 0; exp_perr[g] = 0; txs[g] = 0; idle_st[g] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_dplus", {31'd0, dplus[0]}, 1);
        chk("rst_dminus", {31'd0, dminus[0]}, 0);
        chk("rst_tx_active", {30'd0, tx_active}, 0);
        chk("rst_r_enable", {30'd0, fifo_r_enable}, 0);
        chk("rst_pid_error", {30'd0, pid_error}, 0);
        rst_n = 1'b1;

        repeat (400) @(negedge clk);
        chk("empty_no_pops0", pops[0], 0);
        chk("empty_no_pops1", pops[1], 0);

        t0 = txs[0];
        push_pid(0, 8'hD2);
        wait_idle();
        chk("ack_tx_strobes", txs[0] - t0, 19);
        chk("ack_pops", pops[0], 1);

        t0 = txs[1];
        push_pid(1, 8'h0F);
        wait_idle();
        chk("stuff_tx_strobes", txs[1] - t0, 21);
        chk("stuff_pops", pops[1], 1);

        push_pid(0, 8'h55);
        wait_idle();
        chk("bad_pid_err", perr[0], 1);
        chk("bad_pid_pops", pops[0], 2);

        align_strobe();
        t0 = idle_st[0];
        push_pid(0, 8'hD2);
        push_pid(0, 8'h5A);
        wait_idle();
        chk("b2b_idle_strobes", idle_st[0] - t0, 0);
        chk("b2b_pops", pops[0], 4);

        for (int k = 0; k < 12; k++) begin
            strobe_div = $urandom_range(0, 4);
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                pid = 8'($urandom);
                if ($urandom_range(0, 1) == 1) pid[7:4] = ~pid[3:0];
                push_pid($urandom_range(0, 1), pid);
            end
            wait_idle();
        end
        chk("rand_pops0", pops[0], exp_pops[0]);
        chk("rand_pops1", pops[1], exp_pops[1]);
        chk("rand_perr0", perr[0], exp_perr[0]);
        chk("rand_perr1", perr[1], exp_perr[1]);

        strobe_div = 3;
        s0 = erd[0];
        push_pid(0, 8'hD2);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (erd[0] - s0 >= 10) hit = 1'b1;
        end
        if (!hit) chk("reset_wait_timeout", 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_dplus", {31'd0, dplus[0]}, 1);
        chk("abort_dminus", {31'd0, dminus[0]}, 0);
        chk("abort_tx_active", {31'd0, tx_active[0]}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t0 = pops[0];
        repeat (200) @(negedge clk);
        chk("post_reset_pops", pops[0] - t0, 0);
        chk("post_reset_tx", {30'd0, tx_active}, 0);
        chk("final_pops0", pops[0], exp_pops[0]);
        chk("final_perr0", perr[0], exp_perr[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
